// File: rtl/scarv_cop_mem_bridge_pkg.sv
// Shared definitions for the COP memory-port to req/gnt bus bridge:
// FSM encodings, timeout default and the registered bus request record.
package scarv_cop_mem_bridge_pkg;

  localparam logic [1:0] BR_IDLE = 2'd0;
  localparam logic [1:0] BR_REQ  = 2'd1;
  localparam logic [1:0] BR_WAIT = 2'd2;
  localparam logic [1:0] BR_RSP  = 2'd3;

  localparam int unsigned BR_TIMEOUT_DEFAULT = 255;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ben;
  } bus_txn_t;

  // Reads carry no byte enables on the bus.
  function automatic bus_txn_t br_capture(input logic        wen,
                                          input logic [31:0] addr,
                                          input logic [31:0] wdata,
                                          input logic [3:0]  ben);
    bus_txn_t t;
    t.wen   = wen;
    t.addr  = addr;
    t.wdata = wdata;
    t.ben   = wen ? ben : 4'b0000;
    return t;
  endfunction

endpackage

// File: rtl/scarv_cop_mem_bridge.sv
// Adapts the level-held COP cen/stall memory port to a req/gnt + rvalid bus
// with one outstanding transaction, abort draining and a response timeout.
module scarv_cop_mem_bridge
  import scarv_cop_mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = BR_TIMEOUT_DEFAULT,
  parameter int unsigned TO_W    = 16
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        cop_mem_cen,
  input  logic        cop_mem_wen,
  input  logic [31:0] cop_mem_addr,
  input  logic [31:0] cop_mem_wdata,
  input  logic [3:0]  cop_mem_ben,
  output logic [31:0] cop_mem_rdata,
  output logic        cop_mem_stall,
  output logic        cop_mem_error,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        bus_wen,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_ben,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  bus_txn_t      txn;
  logic [31:0]   rsp_data;
  logic          rsp_err;
  logic          stale;
  logic          abort;
  logic [TO_W-1:0] tcnt;

  logic timeout;
  logic abort_now;

  assign timeout   = (tcnt == TO_W'(TIMEOUT));
  assign abort_now = abort || !cop_mem_cen;

  // NOTE: every variable assigned in always_comb gets a default first,
  // so no path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      BR_IDLE: if (cop_mem_cen && !stale) state_nxt = BR_REQ;
      BR_REQ:  if (bus_gnt)               state_nxt = BR_WAIT;
      BR_WAIT: if (bus_rvalid || timeout) state_nxt = abort_now ? BR_IDLE : BR_RSP;
      BR_RSP:                             state_nxt = BR_IDLE;
      default:                            state_nxt = BR_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state    <= BR_IDLE;
      bus_req  <= 1'b0;
      txn      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      stale    <= 1'b0;
      abort    <= 1'b0;
      tcnt     <= '0;
    end else begin
      state   <= state_nxt;
      bus_req <= (state_nxt == BR_REQ);

      if (state_nxt == BR_IDLE) begin
        abort <= 1'b0;
      end else if (state == BR_REQ || state == BR_WAIT) begin
        abort <= abort_now;
      end

      // A late response to a timed-out transaction may land in RSP or IDLE.
      if (stale && bus_rvalid) stale <= 1'b0;

      case (state)
        BR_IDLE: begin
          if (cop_mem_cen && !stale) begin
            txn  <= br_capture(cop_mem_wen, cop_mem_addr, cop_mem_wdata, cop_mem_ben);
            tcnt <= '0;
          end
        end
        BR_REQ: begin
          if (tcnt != '1) tcnt <= tcnt + 1'b1;
        end
        BR_WAIT: begin
          if (tcnt != '1) tcnt <= tcnt + 1'b1;
          if (bus_rvalid) begin
            rsp_data <= bus_rdata;
            rsp_err  <= bus_err;
          end else if (timeout) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            stale    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_wen   = txn.wen;
  assign bus_addr  = txn.addr;
  assign bus_wdata = txn.wdata;
  assign bus_ben   = txn.ben;

  assign cop_mem_stall = (state != BR_RSP);
  assign cop_mem_rdata = (state == BR_RSP) ? rsp_data : 32'h0;
  assign cop_mem_error = (state == BR_RSP) ? rsp_err  : 1'b0;

endmodule

// File: tb/tb_scarv_cop_mem_bridge.sv
// Self-checking bench for scarv_cop_mem_bridge: a COP-side driver, a
// behavioural bus slave and a monitor comparing against expectation queues.
module tb_scarv_cop_mem_bridge;

  localparam int TIMEOUT = 8;

  logic        g_clk;
  logic        g_resetn;
  logic        cop_mem_cen, cop_mem_wen;
  logic [31:0] cop_mem_addr, cop_mem_wdata;
  logic [3:0]  cop_mem_ben;
  logic [31:0] cop_mem_rdata;
  logic        cop_mem_stall, cop_mem_error;
  logic        bus_req, bus_gnt, bus_wen;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_ben;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  scarv_cop_mem_bridge #(.TIMEOUT(TIMEOUT), .TO_W(16)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .cop_mem_cen(cop_mem_cen), .cop_mem_wen(cop_mem_wen),
    .cop_mem_addr(cop_mem_addr), .cop_mem_wdata(cop_mem_wdata),
    .cop_mem_ben(cop_mem_ben), .cop_mem_rdata(cop_mem_rdata),
    .cop_mem_stall(cop_mem_stall), .cop_mem_error(cop_mem_error),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_wen(bus_wen),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ben(bus_ben),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ben;
  } txn_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  txn_t bus_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Per-transaction slave behaviour, set by the driver before raising cen.
  int          cfg_gnt_dly = 0;
  int          cfg_rsp_dly = 1;
  bit          cfg_err = 0;
  bit          cfg_visible = 1;
  bit          cfg_no_rsp = 0;
  logic [31:0] cfg_rdata = 32'h0;
  bit          late_release = 0;
  int          s_phase = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge g_clk);
    #1;
  endtask

  // Bus slave: grants after cfg_gnt_dly idle cycles, responds cfg_rsp_dly
  // cycles after the grant, or only on late_release for no-response slaves.
  initial begin
    int          s_cnt, s_rsp_dly;
    bit          s_err, s_vis, s_no_rsp;
    logic [31:0] s_rdata;
    s_cnt = 0; s_rsp_dly = 1; s_err = 0; s_vis = 0; s_no_rsp = 0; s_rdata = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0; bus_err = 0;
    forever begin
      @(negedge g_clk);
      bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0; bus_err = 0;
      if (!g_resetn) begin
        s_phase = 0;
        continue;
      end
      if (s_phase == 0 && bus_req) begin
        s_cnt = cfg_gnt_dly; s_rsp_dly = cfg_rsp_dly; s_err = cfg_err;
        s_vis = cfg_visible; s_no_rsp = cfg_no_rsp; s_rdata = cfg_rdata;
        s_phase = 1;
      end
      if (s_phase == 1) begin
        if (s_cnt == 0) begin
          bus_gnt = 1; s_phase = 2; s_cnt = s_rsp_dly;
        end else s_cnt--;
      end else if (s_phase == 2) begin
        if (s_no_rsp) begin
          if (late_release) begin
            bus_rvalid = 1; bus_rdata = $urandom; bus_err = 0; s_phase = 0;
          end
        end else begin
          s_cnt--;
          if (s_cnt == 0) begin
            bus_rvalid = 1; bus_rdata = s_rdata; bus_err = s_err; s_phase = 0;
            if (s_vis) rsp_q.push_back('{data: s_rdata, err: s_err});
          end
        end
      end
    end
  end

  // Monitor: checks each granted request and each COP-visible response.
  initial begin
    logic prev_stall;
    txn_t et;
    rsp_t er;
    prev_stall = 1'b1;
    forever begin
      tick();
      if (g_resetn) begin
        if (bus_req && bus_gnt) begin
          if (bus_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_unexpected: got addr %h, no request expected", bus_addr);
          end else begin
            et = bus_q.pop_front();
            check("bus_txn", {bus_wen, bus_addr, bus_wdata, bus_ben},
                             {et.wen, et.addr, et.wdata, et.ben});
          end
        end
        if (!cop_mem_stall) begin
          check("rsp_single_cycle", prev_stall, 1'b1);
          if (rsp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL cop_unexpected: got rsp data %h err %b, none expected",
                     cop_mem_rdata, cop_mem_error);
          end else begin
            er = rsp_q.pop_front();
            check("cop_rsp", {cop_mem_error, cop_mem_rdata}, {er.err, er.data});
          end
        end else begin
          check("cop_quiet", {cop_mem_error, cop_mem_rdata}, 72'h0);
        end
      end
      prev_stall = cop_mem_stall;
    end
  end

  task automatic start_beat(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] ben, input int gnt_dly, input int rsp_dly,
                            input bit err, input bit visible, input logic [31:0] rdata);
    cfg_gnt_dly = gnt_dly; cfg_rsp_dly = rsp_dly; cfg_err = err;
    cfg_visible = visible; cfg_no_rsp = 0; cfg_rdata = rdata;
    cop_mem_cen = 1; cop_mem_wen = wen; cop_mem_addr = addr;
    cop_mem_wdata = wdata; cop_mem_ben = ben;
    bus_q.push_back('{wen: wen, addr: addr, wdata: wdata, ben: (wen ? ben : 4'b0000)});
  endtask

  task automatic wait_rsp(input string name);
    for (int n = 0; n < 60; n++) begin
      tick();
      if (!cop_mem_stall) return;
    end
    checks++; errors++;
    $display("FAIL %s: got no response within 60 cycles, required one", name);
  endtask

  task automatic wait_req(input string name);
    for (int n = 0; n < 30; n++) begin
      if (bus_req) return;
      tick();
    end
    checks++; errors++;
    $display("FAIL %s: got no bus_req within 30 cycles, required one", name);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic wen;
    g_resetn = 0;
    cop_mem_cen = 0; cop_mem_wen = 0; cop_mem_addr = 0; cop_mem_wdata = 0; cop_mem_ben = 0;
    tick();
    check("reset_bus", {bus_req, bus_wen, bus_addr, bus_wdata, bus_ben}, 72'h0);
    check("reset_cop", {cop_mem_stall, cop_mem_error, cop_mem_rdata}, {1'b1, 1'b0, 32'h0});
    tick();
    g_resetn = 1;
    repeat (2) tick();

    // Load with a 1-cycle grant and rvalid two cycles after the grant.
    start_beat(0, 32'h100, 32'h1234_5678, 4'hF, 0, 2, 0, 1, 32'hDEAD_BEEF);
    wait_rsp("load");
    cop_mem_cen = 0;
    tick();
    check("load_stall_after", cop_mem_stall, 1'b1);

    // Scatter beats back to back, cen held; IDLE separates them.
    start_beat(1, 32'h200, 32'hAAAA_0001, 4'b0001, 0, 1, 0, 1, 32'h0);
    wait_rsp("scatter0");
    start_beat(1, 32'h201, 32'hBBBB_0002, 4'b0010, 0, 1, 0, 1, 32'h0);
    tick();
    check("scatter_gap", {cop_mem_stall, bus_req}, {1'b1, 1'b0});
    wait_rsp("scatter1");
    cop_mem_cen = 0;
    repeat (2) tick();

    // Bus error response.
    start_beat(0, 32'h300, 32'h0, 4'h0, 1, 1, 1, 1, 32'h0);
    wait_rsp("bus_error");
    cop_mem_cen = 0;
    repeat (2) tick();

    // Timeout: granted, no response until released after the error RSP.
    start_beat(0, 32'h400, 32'h0, 4'h0, 0, 1, 0, 0, 32'h0);
    cfg_no_rsp = 1;
    rsp_q.push_back('{data: 32'h0, err: 1'b1});
    wait_req("timeout_req");
    n = 0;
    while (cop_mem_stall && n < 40) begin
      tick();
      n++;
    end
    check("timeout_latency", (n == TIMEOUT || n == TIMEOUT + 1), 1'b1);
    start_beat(0, 32'h500, 32'h0, 4'h0, 0, 1, 0, 1, $urandom);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stale_hold", bus_req, 1'b0);
    end
    late_release = 1;
    tick();
    late_release = 0;
    wait_rsp("after_stale");
    cop_mem_cen = 0;
    repeat (2) tick();

    // Abort in REQ with grant delayed 5 cycles.
    start_beat(1, 32'h600, 32'hCAFE_F00D, 4'hF, 5, 2, 0, 0, 32'h0);
    wait_req("abort_req");
    cop_mem_cen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_req_held", bus_req, 1'b1);
    end
    repeat (12) tick();
    check("abort_idle", {bus_req, cop_mem_stall}, {1'b0, 1'b1});

    // Reset asserted while waiting for a response.
    start_beat(0, 32'h700, 32'h0, 4'h0, 0, 6, 0, 1, 32'h0);
    wait_req("reset_req");
    tick();
    #2 g_resetn = 0;
    #1;
    check("reset_mid", {bus_req, cop_mem_stall, cop_mem_error}, {1'b0, 1'b1, 1'b0});
    cop_mem_cen = 0;
    repeat (2) tick();
    g_resetn = 1;
    repeat (2) tick();
    start_beat(0, 32'h704, 32'h0, 4'h0, 1, 1, 0, 1, 32'h5A5A_1234);
    wait_rsp("post_reset_load");
    cop_mem_cen = 0;
    repeat (2) tick();

    // Randomized beats with occasional aborts and idle gaps.
    for (int i = 0; i < 40; i++) begin
      wen = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        start_beat(wen, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom), $urandom_range(1, 2),
                   $urandom_range(1, 3), 0, 0, $urandom);
        wait_req("rand_abort");
        cop_mem_cen = 0;
        repeat (12) tick();
      end else begin
        start_beat(wen, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom), $urandom_range(0, 2),
                   $urandom_range(1, 3), ($urandom_range(0, 7) == 0), 1, $urandom);
        wait_rsp("rand_beat");
        if ($urandom_range(0, 2) == 0) begin
          cop_mem_cen = 0;
          repeat ($urandom_range(1, 3)) tick();
        end
      end
    end
    cop_mem_cen = 0;
    repeat (20) tick();
    check("rsp_q_drained", rsp_q.size(), 0);
    check("bus_q_drained", bus_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
